// File: rtl/pipeline_pkg.sv
// Shared types for the hazard scoreboard: the in-flight slot record,
// the stall-tracking FSM states and the hard-wired zero register index.
package pipeline_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest;
        logic                 is_load;
    } slot_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dest: REG_ZERO, is_load: 1'b0};

endpackage

// File: rtl/hazard_slot_cmp.sv
// Source-versus-slot match cell: one source register index compared against
// one in-flight slot. Register zero never matches because it is hard-wired.
module hazard_slot_cmp
    import pipeline_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src,
    input  logic                 src_en,
    input  slot_t                slot,
    output logic                 match
);

    assign match = src_en && slot.valid && (src != REG_ZERO) && (src == slot.dest);

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks the destinations of the
// instructions in EX, MEM and WB and stalls ID on a read-after-write hazard.
// Build option HAZARD_FORWARD_EN: when defined, EX/MEM forwarding is assumed
// and only load-use on the EX slot stalls; otherwise EX and MEM both stall.
//
// state | meaning
// RUN   | no stall in the previous cycle
// STALL | ID was held in the previous cycle (counted into stall_cycles)
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs,
    input  logic [$clog2(NUM_REGS)-1:0] id_rt,
    input  logic                        id_uses_rt,
    input  logic                        id_reg_write,
    input  logic                        id_mem_read,
    input  logic [$clog2(NUM_REGS)-1:0] id_dest,
    input  logic                        ex_flush,
    output logic                        pc_write,
    output logic                        if_id_write,
    output logic                        id_ex_bubble,
    output logic                        if_id_flush,
    output logic [CNT_W-1:0]            stall_cycles
);

    // The slot record is sized for the package index width; the default
    // NUM_REGS keeps the two in agreement.
    slot_t      ex_q, mem_q, wb_q;
    slot_t      ex_d;
    hz_state_e  state_q, state_d;
    logic       rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
    logic       hazard;
    logic       stall;
    logic       hz_unused;

    hazard_slot_cmp u_rs_ex  (.src(id_rs), .src_en(1'b1),       .slot(ex_q),  .match(rs_ex_hit));
    hazard_slot_cmp u_rt_ex  (.src(id_rt), .src_en(id_uses_rt), .slot(ex_q),  .match(rt_ex_hit));
    hazard_slot_cmp u_rs_mem (.src(id_rs), .src_en(1'b1),       .slot(mem_q), .match(rs_mem_hit));
    hazard_slot_cmp u_rt_mem (.src(id_rt), .src_en(id_uses_rt), .slot(mem_q), .match(rt_mem_hit));

`ifdef HAZARD_FORWARD_EN
    // Forwarding covers everything except a load whose data is not back yet.
    assign hazard    = id_valid && ex_q.is_load && (rs_ex_hit || rt_ex_hit);
    assign hz_unused = ^{wb_q, mem_q.is_load, rs_mem_hit, rt_mem_hit};
`else
    // No forwarding: any producer still in EX or MEM blocks the read.
    assign hazard    = id_valid && (rs_ex_hit || rt_ex_hit || rs_mem_hit || rt_mem_hit);
    assign hz_unused = ^{wb_q, mem_q.is_load, ex_q.is_load};
`endif

    // A flush kills the instruction in ID, so it overrides any stall.
    assign stall        = hazard && !ex_flush;
    assign pc_write     = !stall;
    assign if_id_write  = !stall;
    assign id_ex_bubble = stall || ex_flush;
    assign if_id_flush  = ex_flush;

    // Next EX slot: only real, non-zero-destination writers that actually issue.
    always_comb begin
        ex_d         = SLOT_EMPTY;
        ex_d.valid   = id_valid && id_reg_write && (id_dest != REG_ZERO) && !stall && !ex_flush;
        ex_d.dest    = id_dest;
        ex_d.is_load = id_mem_read;
    end

    // In-flight table: EX loads from ID, MEM and WB shift unconditionally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Stall-history state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Next state: follow the stall signal, with flush forcing RUN.
    always_comb begin
        state_d = RUN;
        case (state_q)
            RUN:     if (stall && !ex_flush) state_d = STALL;
            STALL:   if (stall && !ex_flush) state_d = STALL;
            default: state_d = RUN;
        endcase
    end

    // Saturating count of edges spent in STALL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (state_q == STALL && stall_cycles != {CNT_W{1'b1}})
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// randomized instruction streams against an age-indexed in-flight model.
module tb_hazard_scoreboard;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                id_valid = 1'b0;
    logic [4:0]          id_rs = '0, id_rt = '0, id_dest = '0;
    logic                id_uses_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic                ex_flush = 1'b0;
    logic                pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic [TB_CNT_W-1:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard #(.NUM_REGS(32), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .ex_flush(ex_flush), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: list of issued writers ordered by age (0 = one stage past ID).
    typedef struct { bit v; bit [4:0] d; bit ld; } rec_t;
    rec_t m_q[$];
    int   m_cnt;
    bit   m_prev_stall;
    bit   m_stall;
    int   bub_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        rec_t e;
        e.v = 0; e.d = 0; e.ld = 0;
        m_q = {e, e, e};
        m_cnt = 0;
        m_prev_stall = 0;
    endfunction

    // A reader conflicts with a writer still younger than the point its value
    // becomes available: age 0 loads with forwarding, ages 0..1 without it.
    function automatic bit m_hazard(bit v, bit [4:0] rs, bit [4:0] rt, bit ur);
        int depth = FWD ? 1 : 2;
        for (int a = 0; a < depth; a++) begin
            bit hit = m_q[a].v && ((rs != 0 && rs == m_q[a].d) || (ur && rt != 0 && rt == m_q[a].d));
            if (hit && (!FWD || m_q[a].ld)) return v;
        end
        return 0;
    endfunction

    task automatic step(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit ur,
                        input bit rw, input bit mr, input bit [4:0] dest, input bit fl);
        rec_t e;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ur;
        id_reg_write = rw; id_mem_read = mr; id_dest = dest; ex_flush = fl;
        #1;
        m_stall = m_hazard(v, rs, rt, ur) && !fl;
        check_val("pc_write",     pc_write,     !m_stall);
        check_val("if_id_write",  if_id_write,  !m_stall);
        check_val("id_ex_bubble", id_ex_bubble, m_stall || fl);
        check_val("if_id_flush",  if_id_flush,  fl);
        check_val("stall_cycles", stall_cycles, m_cnt);
        if (id_ex_bubble) bub_seen++;
        @(posedge clk);
        e.v = v && rw && dest != 0 && !m_stall && !fl;
        e.d = dest; e.ld = mr;
        m_q.push_front(e);
        void'(m_q.pop_back());
        if (m_prev_stall && m_cnt < CNT_MAX) m_cnt++;
        m_prev_stall = m_stall;
    endtask

    // Present one instruction, holding it in ID while the model says it stalls.
    task automatic issue(input bit [4:0] rs, input bit [4:0] rt, input bit ur,
                         input bit rw, input bit mr, input bit [4:0] dest);
        int guard = 0;
        do begin
            step(1, rs, rt, ur, rw, mr, dest, 0);
            guard++;
        end while (m_stall && guard < 8);
        if (m_stall) check_val("issue_timeout", guard, 0);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse starting mid-low-phase, released before the next drive.
    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        m_clear();
        #1;
        check_val("rst_pc_write",     pc_write,     !m_hazard(id_valid, id_rs, id_rt, id_uses_rt));
        check_val("rst_if_id_write",  if_id_write,  !m_hazard(id_valid, id_rs, id_rt, id_uses_rt));
        check_val("rst_if_id_flush",  if_id_flush,  ex_flush);
        check_val("rst_stall_cycles", stall_cycles, 0);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        m_clear();
        do_reset();
        check_val("rst_bubble", id_ex_bubble, 0);
        nops(2);

        // lw $8 then add $9,$8,$1
        do_reset(); bub_seen = 0;
        issue(5'd1, 5'd0, 0, 1, 1, 5'd8);
        issue(5'd8, 5'd1, 1, 1, 0, 5'd9);
        nops(2);
        check_val("loaduse_cnt", stall_cycles, FWD ? 1 : 2);
        check_val("loaduse_bub", bub_seen, FWD ? 1 : 2);

        // add $8 then sub $10,$8,$2
        do_reset(); bub_seen = 0;
        issue(5'd3, 5'd4, 1, 1, 0, 5'd8);
        issue(5'd8, 5'd2, 1, 1, 0, 5'd10);
        nops(2);
        check_val("aluuse_cnt", stall_cycles, FWD ? 0 : 2);
        check_val("aluuse_bub", bub_seen, FWD ? 0 : 2);

        // write to $0 then read $0
        do_reset(); bub_seen = 0;
        issue(5'd1, 5'd0, 0, 1, 1, 5'd0);
        issue(5'd0, 5'd0, 1, 1, 0, 5'd5);
        nops(2);
        check_val("zero_cnt", stall_cycles, 0);
        check_val("zero_bub", bub_seen, 0);

        // flush in the same cycle as a load-use hazard
        do_reset();
        issue(5'd1, 5'd0, 0, 1, 1, 5'd8);
        step(1, 5'd8, 5'd1, 1, 1, 0, 5'd9, 1);
        step(1, 5'd9, 5'd0, 0, 1, 0, 5'd11, 0);
        check_val("flush_no_stall", pc_write, 1);
        nops(2);
        check_val("flush_cnt", stall_cycles, 0);

        // reset pulsed during the second stall cycle
        do_reset();
        issue(5'd3, 5'd4, 1, 1, 0, 5'd8);
        step(1, 5'd8, 5'd2, 1, 1, 0, 5'd10, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        m_clear();
        #1;
        check_val("midrst_cnt", stall_cycles, 0);
        check_val("midrst_pc_write", pc_write, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        step(1, 5'd8, 5'd2, 1, 1, 0, 5'd10, 0);
        check_val("midrst_empty", m_stall, 0);
        nops(2);
        check_val("midrst_cnt_after", stall_cycles, 0);

        // saturate the counter, then one more stall
        do_reset();
        for (int i = 0; i < 20; i++) begin
            issue(5'd1, 5'd0, 0, 1, 1, 5'(8 + (i % 8)));
            issue(5'(8 + (i % 8)), 5'd2, 1, 1, 0, 5'd20);
        end
        nops(2);
        check_val("sat_full", stall_cycles, CNT_MAX);
        issue(5'd1, 5'd0, 0, 1, 1, 5'd8);
        issue(5'd8, 5'd2, 1, 1, 0, 5'd21);
        nops(2);
        check_val("sat_hold", stall_cycles, CNT_MAX);

        // randomized stream, small register range to provoke collisions
        do_reset();
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, meaning architectural register count; register index width is log2(NUM_REGS).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port id_valid  input  1  the IF/ID register holds a real instruction.
REQ-006 SHALL have ports id_rs, id_rt  input  5 each  source register indices of the instruction in ID.
REQ-007 SHALL have port id_uses_rt  input  1  the instruction in ID reads rt; R-type, store and branch instructions set it.
REQ-008 SHALL have ports id_reg_write, id_mem_read  input  1 each  control bits of the instruction in ID.
REQ-009 SHALL have port id_dest  input  5  destination index after the RegDst selection.
REQ-010 SHALL have port ex_flush  input  1  a taken branch or jump resolved in EX; kills the instructions younger than it.
REQ-011 SHALL have ports pc_write, if_id_write  output  1 each  enables for the PC and IF/ID registers.
REQ-012 SHALL have port id_ex_bubble  output  1  forces ID/EX control to zero this cycle.
REQ-013 SHALL have port if_id_flush  output  1  clears IF/ID at the next edge.
REQ-014 SHALL have port stall_cycles  output  CNT_W  saturating count of cycles spent stalled.

Function
REQ-015 SHALL keep a 3-deep in-flight table of slots EX, MEM and WB; each slot holds {valid, dest, is_load}.
REQ-016 SHALL load EX from ID at each edge only if id_valid, id_reg_write and id_dest != 0, and stall and ex_flush are both low; in every other case EX loads invalid.
REQ-017 SHALL shift MEM <= EX and WB <= MEM unconditionally each cycle.
REQ-018 SHALL treat a source as matching a slot when the slot is valid, the source index is nonzero and the index equals the slot dest; rt is considered only when id_uses_rt is high.
REQ-019 SHALL assume a write-before-read register file, so the WB slot never causes a hazard.
REQ-020 SHALL compute the combinational signal hazard as id_valid AND (the hazard rule of REQ-033 or REQ-034).
REQ-021 SHALL, while stall is high, drive pc_write=0, if_id_write=0 and id_ex_bubble=1; all three take their opposite values otherwise.
REQ-022 SHALL define stall as hazard AND NOT ex_flush; ex_flush has priority.
REQ-023 SHALL, on ex_flush, drive if_id_flush=1, id_ex_bubble=1 and pc_write=1 in the same cycle.
REQ-024 SHALL implement a 2-state FSM with states RUN and STALL: RUN goes to STALL when stall is high; STALL stays in STALL while stall is high and returns to RUN when it drops; ex_flush in either state forces RUN.
REQ-025 SHALL give all outputs zero cycles of latency from the inputs; the FSM only records the stall history.
REQ-026 SHALL increment stall_cycles at each edge where the FSM is in STALL, and hold it at all ones once saturated; it never wraps.
REQ-027 SHALL raise a stall for a hazard on both rs and rt exactly as for a single hazard, with no extra cycles.

Reset
REQ-028 SHALL, while reset is high, clear all slot valid bits, set the FSM to RUN and set stall_cycles to 0, asynchronously.
REQ-029 SHALL, during and after reset with id_valid=0, drive pc_write=1, if_id_write=1, id_ex_bubble=0 and if_id_flush=0.
REQ-030 SHALL return to RUN with an empty table when reset is asserted mid-stall; the stalled instruction re-evaluates after reset against that empty table.

Configuration
REQ-031 SHALL use macro HAZARD_FORWARD_EN to select the hazard rule.
REQ-032 SHALL, with HAZARD_FORWARD_EN defined, assume EX/MEM forwarding exists in the datapath.
REQ-033 SHALL, with HAZARD_FORWARD_EN defined, set hazard only for a match on the EX slot when that slot has is_load=1 (load-use), giving a 1-cycle stall.
REQ-034 SHALL, with HAZARD_FORWARD_EN undefined, set hazard for a match on the EX or MEM slot, giving stalls of up to 2 cycles.

Structure
REQ-035 SHALL place the slot record typedef, the FSM state enum and the constant REG_ZERO=0 in the shared package pipeline_pkg.
REQ-036 SHALL contain one sub-module, hazard_slot_cmp, a combinational source-versus-slot match cell instanced per source and per slot.

Verification
REQ-037 SHALL cover, with forwarding: lw $8 then add $9,$8,$1 -> one stall cycle, id_ex_bubble=1 once, stall_cycles=1.
REQ-038 SHALL cover, without forwarding: add $8 then sub $10,$8,$2 -> two stall cycles; with forwarding -> zero stall cycles.
REQ-039 SHALL cover a write to $0 followed by a read of $0 -> no stall in either build.
REQ-040 SHALL cover ex_flush=1 in the same cycle as a load-use hazard -> pc_write=1, if_id_flush=1, FSM in RUN, EX slot invalid next cycle.
REQ-041 SHALL cover reset pulsed during the second stall cycle of the non-forwarding build -> stall_cycles=0 and the table empty afterwards.
REQ-042 SHALL cover stall_cycles preloaded to all ones by a long forced stall, then one more stall cycle -> the value stays at all ones.
